// File: rtl/mips_pc_pkg.sv
// Shared definitions for the fetch program-counter stage: reset address,
// next-PC source select and PC FSM states.
package mips_pc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// 32-bit branch target adder: pc_plus4_id + pre-shifted offset, wrapping mod 2^32.
module branch_target_adder (
    input  logic [31:0] pc_plus4_id,
    input  logic [31:0] branch_offset,
    output logic [31:0] target
);

    assign target = pc_plus4_id + branch_offset;

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with next-PC selection, stall-deferred redirects and
// one-cycle redirect / JR misalignment pulses.
module next_pc_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [31:0] pc_plus4_id,
    input  logic [31:0] branch_offset,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        pending,
    output logic        addr_err
);

    pc_state_t   state;
    pc_sel_t     sel;
    logic        req;
    logic        req_err;
    logic [31:0] br_target;
    logic [31:0] target;
    logic [31:0] hold_tgt;
    logic        hold_err;
    logic [31:0] release_tgt;
    logic        release_err;

    branch_target_adder u_br_adder (
        .pc_plus4_id   (pc_plus4_id),
        .branch_offset (branch_offset),
        .target        (br_target)
    );

    always_comb begin
        sel = SEL_SEQ;
        if (jr)
            sel = SEL_JR;
        else if (jump)
            sel = SEL_J;
        else if (branch_taken)
            sel = SEL_BR;
    end

    assign req     = (sel != SEL_SEQ);
    assign req_err = (sel == SEL_JR) && (jr_target[1:0] != 2'b00);

    always_comb begin
        target = '0;
        case (sel)
            SEL_BR:  target = br_target;
            SEL_J:   target = {pc_plus4_id[31:28], jump_index, 2'b00};
            SEL_JR:  target = {jr_target[31:2], 2'b00};
            default: target = '0;
        endcase
    end

    // A new request arriving on the release cycle overrides the latched one.
    assign release_tgt = req ? target  : hold_tgt;
    assign release_err = req ? req_err : hold_err;

    assign pending = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            pc_plus4 <= RESET_PC + 32'd4;
            redirect <= 1'b0;
            addr_err <= 1'b0;
            hold_tgt <= '0;
            hold_err <= 1'b0;
        end else begin
            redirect <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (req) begin
                            pc       <= target;
                            pc_plus4 <= target + 32'd4;
                            redirect <= 1'b1;
                            addr_err <= req_err;
                        end else begin
                            pc       <= pc_plus4;
                            pc_plus4 <= pc_plus4 + 32'd4;
                        end
                    end else if (req) begin
                        hold_tgt <= target;
                        hold_err <= req_err;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stall) begin
                        if (req) begin
                            hold_tgt <= target;
                            hold_err <= req_err;
                        end
                    end else begin
                        pc       <= release_tgt;
                        pc_plus4 <= release_tgt + 32'd4;
                        redirect <= 1'b1;
                        addr_err <= release_err;
                        state    <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
